// File: rtl/pipe_issue_scheduler.sv
// In-order issue controller for the register/ALU/writeback/store pipeline: buffers
// instructions in a small FIFO and replaces RAW-hazarded slots with scratch bubbles.
module pipe_issue_scheduler #(
  parameter int         DEPTH     = 4,
  parameter int         HAZ_DEPTH = 1,
  parameter logic [3:0] NOP_REG   = 4'hF,
  parameter logic [7:0] NOP_ADDR  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_rd,
  input  logic [3:0]             in_rs1,
  input  logic [3:0]             in_rs2,
  input  logic [3:0]             in_func,
  input  logic [7:0]             in_addr,
  output logic [3:0]             rd,
  output logic [3:0]             rs1,
  output logic [3:0]             rs2,
  output logic [3:0]             func,
  output logic [7:0]             addr,
  output logic                   issue_valid,
  output logic                   hazard_stall,
  output logic [$clog2(DEPTH):0] queue_level,
  output logic [15:0]            issue_cnt,
  output logic [15:0]            stall_cnt,
  output logic                   rsv_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  function automatic logic reads_rs1(input logic [3:0] f);
    case (f)
      4'd0, 4'd1, 4'd2: reads_rs1 = 1'b1;
      default:          reads_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [3:0] f);
    case (f)
      4'd0, 4'd1: reads_rs2 = 1'b1;
      default:    reads_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rsv(input logic [3:0] d, input logic [3:0] s1,
                                    input logic [3:0] s2);
    uses_rsv = (d == NOP_REG) || (s1 == NOP_REG) || (s2 == NOP_REG);
  endfunction

  logic [23:0]                 mem_r [DEPTH];
  logic [AW-1:0]               wr_ptr_r;
  logic [AW-1:0]               rd_ptr_r;
  logic [AW:0]                 count_r;
  logic [HAZ_DEPTH-1:0]        sb_valid_r;
  logic [HAZ_DEPTH-1:0][3:0]   sb_rd_r;

  logic                        push_s;
  logic                        issue_s;
  logic                        empty_s;
  logic                        blocked_s;
  logic [3:0]                  head_rd_s;
  logic [3:0]                  head_rs1_s;
  logic [3:0]                  head_rs2_s;
  logic [3:0]                  head_func_s;
  logic [7:0]                  head_addr_s;

  assign in_ready    = (count_r != FULL_LVL);
  assign queue_level = count_r;
  assign push_s      = in_valid && in_ready;
  assign empty_s     = (count_r == '0);
  assign issue_s     = !empty_s && !blocked_s;
  assign {head_rd_s, head_rs1_s, head_rs2_s, head_func_s, head_addr_s} = mem_r[rd_ptr_r];

  // Head is blocked when a recently issued rd matches an operand it actually reads.
  always_comb begin
    blocked_s = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_valid_r[i] &&
          ((reads_rs1(head_func_s) && (sb_rd_r[i] == head_rs1_s)) ||
           (reads_rs2(head_func_s) && (sb_rd_r[i] == head_rs2_s)))) begin
        blocked_s = 1'b1;
      end else begin
        blocked_s = blocked_s;
      end
    end
  end

  // FIFO storage; stale entries are harmless because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_rd, in_rs1, in_rs2, in_func, in_addr};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (issue_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, issue_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Scoreboard of destinations still in flight; bubbles enter as invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_r <= '0;
      sb_rd_r    <= '0;
    end else begin
      sb_valid_r[0] <= issue_s;
      sb_rd_r[0]    <= issue_s ? head_rd_s : 4'h0;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_valid_r[i] <= sb_valid_r[i-1];
        sb_rd_r[i]    <= sb_rd_r[i-1];
      end
    end
  end

  // Slot registers: either the head instruction or a scratch-register bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd           <= NOP_REG;
      rs1          <= NOP_REG;
      rs2          <= NOP_REG;
      func         <= 4'b0000;
      addr         <= NOP_ADDR;
      issue_valid  <= 1'b0;
      hazard_stall <= 1'b0;
    end else if (issue_s) begin
      rd           <= head_rd_s;
      rs1          <= head_rs1_s;
      rs2          <= head_rs2_s;
      func         <= head_func_s;
      addr         <= head_addr_s;
      issue_valid  <= 1'b1;
      hazard_stall <= 1'b0;
    end else begin
      rd           <= NOP_REG;
      rs1          <= NOP_REG;
      rs2          <= NOP_REG;
      func         <= 4'b0000;
      addr         <= NOP_ADDR;
      issue_valid  <= 1'b0;
      hazard_stall <= !empty_s;
    end
  end

  // Wrapping statistics and the sticky reserved-register flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= 16'd0;
      stall_cnt <= 16'd0;
      rsv_err   <= 1'b0;
    end else begin
      if (issue_s) issue_cnt <= issue_cnt + 16'd1;
      if (!empty_s && blocked_s) stall_cnt <= stall_cnt + 16'd1;
      if (push_s && uses_rsv(in_rd, in_rs1, in_rs2)) rsv_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// Scoreboard bench for pipe_issue_scheduler: directed pushes queue expected issues,
// a negedge monitor compares every slot; directed checks cover stalls, fill and reset.
module tb_pipe_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd, in_rs1, in_rs2, in_func;
  logic [7:0]  in_addr;
  logic [3:0]  rd, rs1, rs2, func;
  logic [7:0]  addr;
  logic        issue_valid;
  logic        hazard_stall;
  logic [2:0]  queue_level;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
  logic        rsv_err;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] expq[$];
  logic [23:0] mon_exp;

  pipe_issue_scheduler #(.DEPTH(4), .HAZ_DEPTH(1), .NOP_REG(4'hF), .NOP_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func(in_func), .in_addr(in_addr),
    .rd(rd), .rs1(rs1), .rs2(rs2), .func(func), .addr(addr),
    .issue_valid(issue_valid), .hazard_stall(hazard_stall), .queue_level(queue_level),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt), .rsv_err(rsv_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: real slots must match the queue head, other slots the bubble encoding.
  always @(negedge clk) begin
    if (!rst) begin
      if (issue_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual=%0h required=none", {rd, rs1, rs2, func, addr});
        end else begin
          mon_exp = expq.pop_front();
          check("issue_fields", {8'h00, rd, rs1, rs2, func, addr}, {8'h00, mon_exp});
        end
      end else begin
        check("bubble_fields", {8'h00, rd, rs1, rs2, func, addr}, 32'h00FFF0FF);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, return at the following negedge.
  task automatic push(input logic [3:0] r, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] f, input logic [7:0] a);
    int n = 0;
    in_valid = 1'b1;
    in_rd = r; in_rs1 = s1; in_rs2 = s2; in_func = f; in_addr = a;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_bound actual=%0d required=<50", n);
    end else begin
      expq.push_back({r, s1, s2, f, a});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (queue_level != 3'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", 32'(n < 100), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    in_rd = 4'd0; in_rs1 = 4'd0; in_rs2 = 4'd0; in_func = 4'd0; in_addr = 8'd0;
    do_reset();

    // Reset state
    check("rst_out_fields", {8'h00, rd, rs1, rs2, func, addr}, 32'h00FFF0FF);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_hazard_stall", 32'(hazard_stall), 32'd0);
    check("rst_queue_level", 32'(queue_level), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_rsv_err", 32'(rsv_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Independent stream: add then sub, consecutive slots
    push(4'd1, 4'd2, 4'd3, 4'd0, 8'h11);
    push(4'd4, 4'd5, 4'd6, 4'd1, 8'h22);
    check("indep_first_valid", 32'(issue_valid), 32'd1);
    @(negedge clk);
    check("indep_second_valid", 32'(issue_valid), 32'd1);
    check("indep_second_stall", 32'(hazard_stall), 32'd0);
    check("indep_issue_cnt", 32'(issue_cnt), 32'd2);
    check("indep_stall_cnt", 32'(stall_cnt), 32'd0);

    // RAW with HAZ_DEPTH=1
    do_reset();
    push(4'd1, 4'd2, 4'd3, 4'd0, 8'h01);
    push(4'd5, 4'd1, 4'd6, 4'd0, 8'h02);
    check("raw_slot1_valid", 32'(issue_valid), 32'd1);
    @(negedge clk);
    check("raw_slot2_valid", 32'(issue_valid), 32'd0);
    check("raw_slot2_stall", 32'(hazard_stall), 32'd1);
    check("raw_slot2_rd", 32'(rd), 32'hF);
    check("raw_slot2_addr", 32'(addr), 32'hFF);
    @(negedge clk);
    check("raw_slot3_valid", 32'(issue_valid), 32'd1);
    check("raw_stall_cnt", 32'(stall_cnt), 32'd1);
    @(negedge clk);
    check("empty_bubble_stall", 32'(hazard_stall), 32'd0);

    // Operand use: nega ignores rs2, add does not
    do_reset();
    push(4'd2, 4'd1, 4'd0, 4'd2, 8'h30);
    push(4'd3, 4'd3, 4'd2, 4'd2, 8'h31);
    push(4'd2, 4'd1, 4'd0, 4'd2, 8'h32);
    check("nega_no_stall_valid", 32'(issue_valid), 32'd1);
    check("nega_no_stall_flag", 32'(hazard_stall), 32'd0);
    push(4'd6, 4'd5, 4'd2, 4'd0, 8'h33);
    check("nega3_valid", 32'(issue_valid), 32'd1);
    @(negedge clk);
    check("add_rs2_stall", 32'(hazard_stall), 32'd1);
    @(negedge clk);
    check("add_rs2_issue", 32'(issue_valid), 32'd1);
    check("operand_stall_cnt", 32'(stall_cnt), 32'd1);
    check("operand_issue_cnt", 32'(issue_cnt), 32'd4);

    // Full FIFO via a dependency chain that issues every other slot
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      push(4'(k), 4'(k - 1), 4'(k - 1), 4'd0, 8'(k));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(queue_level), 32'd4);
    in_valid = 1'b1;
    in_rd = 4'd8; in_rs1 = 4'd7; in_rs2 = 4'd7; in_func = 4'd0; in_addr = 8'h08;
    expq.push_back({4'd8, 4'd7, 4'd7, 4'd0, 8'h08});
    @(negedge clk);
    check("after_pop_level", 32'(queue_level), 32'd3);
    check("after_pop_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("refill_level", 32'(queue_level), 32'd4);
    drain();
    check("chain_issue_cnt", 32'(issue_cnt), 32'd8);
    check("chain_stall_cnt", 32'(stall_cnt), 32'd7);
    check("chain_expq_empty", 32'(expq.size()), 32'd0);

    // Reset mid-stream with three queued
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push(4'(k), 4'(k - 1), 4'(k - 1), 4'd0, 8'(8'h40 + k));
    end
    check("pre_rst_level", 32'(queue_level), 32'd3);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    check("midrst_valid", 32'(issue_valid), 32'd0);
    check("midrst_level", 32'(queue_level), 32'd0);
    check("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("midrst_rd", 32'(rd), 32'hF);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("post_rst_issue_cnt", 32'(issue_cnt), 32'd0);

    // Counter wrap and reserved register
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      push(4'd1, 4'd0, 4'd0, 4'd3, 8'(i));
    end
    drain();
    check("preload_issue_cnt", 32'(issue_cnt), 32'hFFFF);
    check("preload_rsv_err", 32'(rsv_err), 32'd0);
    push(4'hF, 4'd0, 4'd0, 4'd3, 8'h20);
    check("rsv_err_set", 32'(rsv_err), 32'd1);
    @(negedge clk);
    check("wrap_issue_cnt", 32'(issue_cnt), 32'd0);
    check("wrap_stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (3) @(negedge clk);
    check("rsv_err_sticky", 32'(rsv_err), 32'd1);
    check("final_expq_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
